// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;

    function automatic int addr_w(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int acc_w(input int n, input int data_w);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate; emits one C element when the last product of a dot product arrives.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = addr_w(N_DEF),
    parameter int ACC_W  = acc_w(N_DEF, DATA_W_DEF)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              first_i,
    input  logic              last_i,
    input  logic              valid_i,
    input  logic [AW-1:0]     dst_addr_i,
    output logic              c_we_o,
    output logic [AW-1:0]     c_addr_o,
    output logic [ACC_W-1:0]  c_wdata_o
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    sum_d;
    logic [ACC_W-1:0]    acc_q;
    logic                c_we_q;
    logic [AW-1:0]       c_addr_q;
    logic [ACC_W-1:0]    c_wdata_q;

    assign prod  = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    // The first product of a dot product replaces the accumulator instead of adding to it.
    assign sum_d = (first_i ? '0 : acc_q) + {{(ACC_W-2*DATA_W){1'b0}}, prod};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q     <= '0;
            c_we_q    <= 1'b0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
        end else begin
            c_we_q <= 1'b0;
            if (valid_i) begin
                acc_q <= sum_d;
                if (last_i) begin
                    c_we_q    <= 1'b1;
                    c_addr_q  <= dst_addr_i;
                    c_wdata_q <= sum_d;
                end
            end
        end
    end

    assign c_we_o    = c_we_q;
    assign c_addr_o  = c_addr_q;
    assign c_wdata_o = c_wdata_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for C = A x B: walks (i,j,k) row-major, drives RAM addresses and feeds the MAC one cycle later.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int N      = N_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int AW     = addr_w(N),
    localparam int ACC_W  = acc_w(N, DATA_W)
) (
    input  logic              CLOCK_100,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     a_addr,
    output logic [AW-1:0]     b_addr,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              c_we,
    output logic [AW-1:0]     c_addr,
    output logic [ACC_W-1:0]  c_wdata
);

    localparam int LW = $clog2(N);

    state_t          state_q;
    logic [LW-1:0]   i_q, j_q, k_q;
    logic [LW-1:0]   i_d, j_d, k_d;
    logic            drain_q;
    logic            busy_q, done_q;
    logic [AW-1:0]   a_addr_q, b_addr_q;
    logic            v1_q, first1_q, last1_q;
    logic [AW-1:0]   dst1_q;
    logic            last_triple;

    // N is a power of two, so i*N+k is just {i,k} and counters wrap for free.
    always_comb begin
        k_d = k_q + 1'b1;
        j_d = j_q;
        i_d = i_q;
        if (k_q == '1) begin
            j_d = j_q + 1'b1;
            if (j_q == '1) begin
                i_d = i_q + 1'b1;
            end
        end
    end

    assign last_triple = (i_q == '1) && (j_q == '1) && (k_q == '1);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLOCK_100) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            dst1_q   <= '0;
        end else begin
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // Tag the triple on the address bus so the MAC sees it alongside the RAM data.
                    v1_q     <= 1'b1;
                    first1_q <= (k_q == '0);
                    last1_q  <= (k_q == '1);
                    dst1_q   <= {i_q, j_q};
                    if (last_triple) begin
                        state_q <= DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        i_q      <= i_d;
                        j_q      <= j_d;
                        k_q      <= k_d;
                        a_addr_q <= {i_d, k_d};
                        b_addr_q <= {k_d, j_d};
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk_i      (CLOCK_100),
        .reset_i    (reset),
        .a_i        (a_rdata),
        .b_i        (b_rdata),
        .first_i    (first1_q),
        .last_i     (last1_q),
        .valid_i    (v1_q),
        .dst_addr_i (dst1_q),
        .c_we_o     (c_we),
        .c_addr_o   (c_addr),
        .c_wdata_o  (c_wdata)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_addr = a_addr_q;
    assign b_addr = b_addr_q;

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that computes C = A x B for N x N unsigned matrices held in three external synchronous RAMs.
- It issues row-major read addresses for A and B and accumulates products with an internal MAC. Each finished C element is written to the C RAM.
- It sits between the board-level ChipInterface (start from BTN/SW decode, done/busy to display logic) and the matrix memories.

Parameters:
- N, 4, matrix dimension; power of two, N >= 2
- DATA_W, 8, element width of A and B
- AW, $clog2(N*N), RAM address width (derived)
- ACC_W, 2*DATA_W+$clog2(N), accumulator / C element width (derived)

Ports:
- CLOCK_100  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request one multiplication; sampled only in IDLE or DONE
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle completion pulse
- a_addr  output  AW  A read address = i*N+k
- b_addr  output  AW  B read address = k*N+j
- a_rdata  input  DATA_W  A RAM data, valid one cycle after a_addr
- b_rdata  input  DATA_W  B RAM data, valid one cycle after b_addr
- c_we  output  1  C write strobe
- c_addr  output  AW  C write address = i*N+j
- c_wdata  output  ACC_W  C element value

Behaviour:
- Reset values (all outputs): state=IDLE, busy=0, done=0, c_we=0, a_addr=b_addr=c_addr=0, c_wdata=0; i, j, k counters and acc = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE, start=1 -> RUN.
  - RUN, last triple issued (i=j=k=N-1) -> DRAIN.
  - DRAIN is exactly 2 cycles -> DONE.
  - DONE, start=1 -> RUN (back-to-back); otherwise -> IDLE.
- Timing, with start sampled high at the end of cycle 0:
  - RUN occupies cycles 1..N^3. One (i,j,k) triple is issued per cycle, k innermost, then j, then i.
  - DRAIN occupies cycles N^3+1 and N^3+2. DONE is cycle N^3+3, where done=1 and busy=0.
  - busy=1 in RUN and DRAIN only.
- Pipeline:
  - Addresses are issued in cycle t and the RAM data is consumed in cycle t+1.
  - The product of the k=0 data loads acc (acc = p); the product of k>0 data adds to it (acc = acc + p).
  - At the edge that consumes k=N-1 data, c_wdata <= acc + p and c_addr <= i*N+j of that triple (carried down the pipeline). c_we is high for exactly one cycle, t+2.
- Write count: N^2 writes per run, one every N cycles. The last write is in cycle N^3+2.
- Arithmetic: all unsigned. The product is 2*DATA_W bits; acc is ACC_W bits, so overflow is impossible.
- Address outputs hold their last value outside RUN. a_rdata and b_rdata are ignored outside the consume cycle.
- start while busy=1 is ignored; no queuing.
- reset asserted mid-run: the next cycle is IDLE with all outputs at reset values. The pending c_we is cancelled. No done pulse is generated.
- start held high continuously: a new run begins at each DONE, so done pulses every N^3+3 cycles.

Decomposition:
- Package matmul_pkg holds:
  - typedef state_t (IDLE, RUN, DRAIN, DONE)
  - default N and DATA_W constants
  - helper functions for AW and ACC_W
- One sub-module, matmul_mac, owns the registered multiply-accumulate. Inputs: a, b, first, last, valid, dst_addr. Outputs: c_we, c_addr, c_wdata.
- The sequencer proper owns the FSM, the i/j/k counters and address generation.

Test Plan:
- Identity x B, with N=4, A=I and B[r][c]=r*4+c: after start, C RAM equals B, 16 writes observed, done in cycle 67 relative to the start cycle, busy high in cycles 1..66.
- All-max, with N=4 and A=B=255 everywhere: every c_wdata = 260100 (0x3F804), no truncation at ACC_W=18.
- Ordering, with A[r][c]=r+1 and B[r][c]=c+1: c_addr sequence is 0..15 in order, C[i][j] = 4*(i+1)*(j+1), c_we spacing exactly 4 cycles.
- start pulsed in cycles 10 and 40 of a run: ignored, exactly one done, 16 writes.
- reset asserted in cycle 30 of a run: next cycle busy=0, c_we=0, all address outputs 0, no done. A subsequent start completes correctly with done 67 cycles later.
- start held high for 200 cycles: done pulses in cycles 67 and 134, 32 writes total, with no IDLE cycle between runs.
